// File: rtl/sobel_pkg.sv
// rtl/sobel_pkg.sv - shared types and default geometry for the Sobel window generator and gradient units
package sobel_pkg;

  localparam int PIXEL_W   = 24;
  localparam int DEF_IMG_W = 640;
  localparam int DEF_IMG_H = 480;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // Six taps of one gradient: +1/+2/+1 group followed by -1/-2/-1 group
  typedef struct packed {
    pixel_t p1a;
    pixel_t p2;
    pixel_t p1b;
    pixel_t m1a;
    pixel_t m2;
    pixel_t m1b;
  } sobel_taps_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - single-clock line RAM, combinational read of the old word before the write lands
module sobel_line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read side sees the stored word for this address; the write only takes effect at the edge
  always_comb begin
    rdata = mem[addr];
  end

  // Write the new word for the current column
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// rtl/sobel_window_gen.sv - streaming 3x3 window generator producing Gx/Gy tap groups from a raster pixel stream
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H,
  parameter int PIX_W = PIXEL_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             out_valid,
  output logic             out_eof,
  output logic [PIX_W-1:0] gx_p1a,
  output logic [PIX_W-1:0] gx_p2,
  output logic [PIX_W-1:0] gx_p1b,
  output logic [PIX_W-1:0] gx_m1a,
  output logic [PIX_W-1:0] gx_m2,
  output logic [PIX_W-1:0] gx_m1b,
  output logic [PIX_W-1:0] gy_p1a,
  output logic [PIX_W-1:0] gy_p2,
  output logic [PIX_W-1:0] gy_p1b,
  output logic [PIX_W-1:0] gy_m1a,
  output logic [PIX_W-1:0] gy_m2,
  output logic [PIX_W-1:0] gy_m1b
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [CW-1:0]    eff_col;
  logic [RW-1:0]    eff_row;
  logic             emit;
  logic             last_pix;
  logic [PIX_W-1:0] lb0_rdata;
  logic [PIX_W-1:0] lb1_rdata;

  // The 3x3 window is the two stored columns plus the incoming column {lb1, lb0, in_pixel}.
  // Index 0 = top row, 1 = middle row, 2 = bottom row.
  logic [PIX_W-1:0] win_l [3];
  logic [PIX_W-1:0] win_m [3];
  logic [PIX_W-1:0] col_new [3];

  // Effective position of the current pixel; a valid SOF forces (0,0)
  always_comb begin
    eff_col = col;
    eff_row = row;
    if (in_valid && in_sof) begin
      eff_col = '0;
      eff_row = '0;
    end
    emit       = in_valid && (eff_col >= COL_TWO) && (eff_row >= ROW_TWO);
    last_pix   = (eff_col == COL_LAST) && (eff_row == ROW_LAST);
    col_new[0] = lb1_rdata;
    col_new[1] = lb0_rdata;
    col_new[2] = in_pixel;
  end

  // lb0 holds the previous line; its old word cascades into lb1 (line before that)
  sobel_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb0 (
    .clk   (clk),
    .we    (in_valid),
    .addr  (eff_col),
    .wdata (in_pixel),
    .rdata (lb0_rdata)
  );

  sobel_line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (PIX_W)
  ) u_lb1 (
    .clk   (clk),
    .we    (in_valid),
    .addr  (eff_col),
    .wdata (lb0_rdata),
    .rdata (lb1_rdata)
  );

  // Raster position counters, advanced once per accepted pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col <= '0;
      row <= '0;
    end else if (in_valid) begin
      if (eff_col == COL_LAST) begin
        col <= '0;
        row <= (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
      end else begin
        col <= eff_col + CW'(1);
        row <= eff_row;
      end
    end
  end

  // Shift the window one column left on every accepted pixel
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 3; r++) begin
        win_l[r] <= '0;
        win_m[r] <= '0;
      end
    end else if (in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_l[r] <= win_m[r];
        win_m[r] <= col_new[r];
      end
    end
  end

  // Register one output beat per emitting pixel; taps hold between beats
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_eof   <= 1'b0;
      gx_p1a    <= '0;
      gx_p2     <= '0;
      gx_p1b    <= '0;
      gx_m1a    <= '0;
      gx_m2     <= '0;
      gx_m1b    <= '0;
      gy_p1a    <= '0;
      gy_p2     <= '0;
      gy_p1b    <= '0;
      gy_m1a    <= '0;
      gy_m2     <= '0;
      gy_m1b    <= '0;
    end else begin
      out_valid <= emit;
      out_eof   <= emit && last_pix;
      if (emit) begin
        gx_p1a <= col_new[0];
        gx_p2  <= col_new[1];
        gx_p1b <= col_new[2];
        gx_m1a <= win_l[0];
        gx_m2  <= win_l[1];
        gx_m1b <= win_l[2];
        gy_p1a <= win_l[2];
        gy_p2  <= win_m[2];
        gy_p1b <= col_new[2];
        gy_m1a <= win_l[0];
        gy_m2  <= win_m[0];
        gy_m1b <= col_new[0];
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb/tb_sobel_window_gen.sv - directed and table-driven bench for sobel_window_gen on a 4x4 frame
module tb_sobel_window_gen;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 24;

  typedef logic [288:0] beat_t;
  typedef struct {
    int              r;
    int              c;
    logic [11:0][7:0] lo;
    logic            eof;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic          out_valid;
  logic          out_eof;
  logic [PW-1:0] gx_p1a, gx_p2, gx_p1b, gx_m1a, gx_m2, gx_m1b;
  logic [PW-1:0] gy_p1a, gy_p2, gy_p1b, gy_m1a, gy_m2, gy_m1b;

  int    checks = 0;
  int    failures = 0;
  int    b2b = 0;
  int    eof_stray = 0;
  logic  prev_v = 1'b0;
  beat_t got_q[$];
  beat_t exp_q[$];
  vec_t  vecs[4];
  logic [PW-1:0] pix [H][W];

  always #5 clk = ~clk;

  sobel_window_gen #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (PW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_eof   (out_eof),
    .gx_p1a    (gx_p1a),
    .gx_p2     (gx_p2),
    .gx_p1b    (gx_p1b),
    .gx_m1a    (gx_m1a),
    .gx_m2     (gx_m2),
    .gx_m1b    (gx_m1b),
    .gy_p1a    (gy_p1a),
    .gy_p2     (gy_p2),
    .gy_p1b    (gy_p1b),
    .gy_m1a    (gy_m1a),
    .gy_m2     (gy_m2),
    .gy_m1b    (gy_m1b)
  );

  function automatic beat_t dut_beat();
    return {gx_p1a, gx_p2, gx_p1b, gx_m1a, gx_m2, gx_m1b,
            gy_p1a, gy_p2, gy_p1b, gy_m1a, gy_m2, gy_m1b, out_eof};
  endfunction

  always @(negedge clk) begin
    if (out_valid) got_q.push_back(dut_beat());
    if (out_valid && prev_v) b2b++;
    if (out_eof && !out_valid) eof_stray++;
    prev_v = out_valid;
  end

  task automatic chk(input string name, input beat_t act, input beat_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send(input logic sof, input logic [PW-1:0] p, input int gap);
    @(negedge clk);
    in_valid = 1'b1;
    in_sof   = sof;
    in_pixel = p;
    if (gap != 0) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b1;
      in_pixel = ~p;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_sof   = 1'b0;
    end
  endtask

  // Pattern frame: low byte = row*16+col, upper bytes carry a frame tag
  task automatic pat_frame(input logic [7:0] fr, input int gap, input int stop_at);
    for (int i = 0; i < W * H; i++) begin
      if (i == stop_at) return;
      send(i == 0, {fr, fr, 8'(((i / W) * 16) + (i % W))}, gap);
    end
  endtask

  task automatic push_table(input logic [7:0] fr);
    for (int v = 0; v < 4; v++) begin
      logic [11:0][23:0] t;
      for (int k = 0; k < 12; k++) t[k] = {fr, fr, vecs[v].lo[k]};
      exp_q.push_back({t, vecs[v].eof});
    end
  endtask

  function automatic beat_t model_beat(input int r, input int c, input logic eof);
    logic [11:0][23:0] t;
    t[11] = pix[r-2][c];   t[10] = pix[r-1][c];   t[9] = pix[r][c];
    t[8]  = pix[r-2][c-2]; t[7]  = pix[r-1][c-2]; t[6] = pix[r][c-2];
    t[5]  = pix[r][c-2];   t[4]  = pix[r][c-1];   t[3] = pix[r][c];
    t[2]  = pix[r-2][c-2]; t[1]  = pix[r-2][c-1]; t[0] = pix[r-2][c];
    return {t, eof};
  endfunction

  task automatic compare(input string tag);
    int n;
    chk_int({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{r: 2, c: 2, eof: 1'b0,
                lo: {8'h02, 8'h12, 8'h22, 8'h00, 8'h10, 8'h20,
                     8'h20, 8'h21, 8'h22, 8'h00, 8'h01, 8'h02}};
    vecs[1] = '{r: 2, c: 3, eof: 1'b0,
                lo: {8'h03, 8'h13, 8'h23, 8'h01, 8'h11, 8'h21,
                     8'h21, 8'h22, 8'h23, 8'h01, 8'h02, 8'h03}};
    vecs[2] = '{r: 3, c: 2, eof: 1'b0,
                lo: {8'h12, 8'h22, 8'h32, 8'h10, 8'h20, 8'h30,
                     8'h30, 8'h31, 8'h32, 8'h10, 8'h11, 8'h12}};
    vecs[3] = '{r: 3, c: 3, eof: 1'b1,
                lo: {8'h13, 8'h23, 8'h33, 8'h11, 8'h21, 8'h31,
                     8'h31, 8'h32, 8'h33, 8'h11, 8'h12, 8'h13}};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_state", dut_beat(), '0);
    chk_int("reset_valid", int'(out_valid), 0);
    reset = 1'b1;

    // 1: continuous frame
    pat_frame(8'h00, 0, W * H);
    idle(3);
    push_table(8'h00);
    compare("cont");

    // 2: gapped frame, in_sof high during gaps must be ignored
    b2b = 0;
    pat_frame(8'h55, 1, W * H);
    idle(3);
    push_table(8'h55);
    compare("gap");
    chk_int("gap_no_b2b", b2b, 0);

    // 3: two back-to-back frames with distinct tags
    pat_frame(8'hA1, 0, W * H);
    pat_frame(8'hB2, 0, W * H);
    idle(3);
    push_table(8'hA1);
    push_table(8'hB2);
    compare("b2b");

    // 4: abort at pixel index 9, then a full frame
    pat_frame(8'h3C, 0, 9);
    pat_frame(8'hC3, 0, W * H);
    idle(3);
    push_table(8'hC3);
    compare("abort");

    // 5: async reset while a beat is on the outputs
    pat_frame(8'h77, 0, 11);
    @(negedge clk);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    chk_int("pre_reset_valid", int'(out_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_outputs", dut_beat(), '0);
    chk_int("async_reset_valid", int'(out_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    got_q.delete();
    pat_frame(8'h99, 0, W * H);
    idle(3);
    push_table(8'h99);
    compare("post_reset");

    // 6: random frame with random gaps against a window model
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        pix[r][c] = 24'($urandom);
        send((r == 0) && (c == 0), pix[r][c], int'($urandom_range(0, 1)));
      end
    end
    idle(3);
    for (int r = 2; r < H; r++) begin
      for (int c = 2; c < W; c++) begin
        exp_q.push_back(model_beat(r, c, (r == H - 1) && (c == W - 1)));
      end
    end
    compare("rand");

    chk_int("eof_without_valid", eof_stray, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
